// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ requesters.
// Each grant lasts up to MAX_BURST beats and is followed by one idle cycle.
module fifo_wr_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    input  logic                   fifo_full,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       grant,
    output logic                   fifo_w_en,
    output logic [WIDTH-1:0]       fifo_data,
    output logic                   busy
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state_reg, state_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] last_grant_reg, last_grant_next;
    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;

    logic [WIDTH-1:0] slice [N_REQ];
    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] scan_idx;
    int               scan_pos;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign slice[gi] = req_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Scan from the farthest position back to the nearest so the requester
    // closest after last_grant is the one left selected.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        scan_pos  = 0;
        scan_idx  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            scan_pos = (int'(last_grant_reg) + k) % N_REQ;
            scan_idx = IDX_W'(scan_pos);
            if (req[scan_idx]) begin
                sel_found = 1'b1;
                sel_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        burst_cnt_next  = burst_cnt_reg;
        req_ready       = '0;
        fifo_w_en       = 1'b0;
        fifo_data       = '0;
        case (state_reg)
            IDLE: begin
                if (sel_found) begin
                    state_next     = GRANT;
                    owner_next     = sel_idx;
                    grant_next     = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                    burst_cnt_next = '0;
                end
            end
            GRANT: begin
                // Outputs are gated by rst_n so a reset edge never carries a write.
                req_ready[owner_reg] = rst_n && !fifo_full;
                fifo_w_en            = rst_n && req[owner_reg] && !fifo_full;
                fifo_data            = rst_n ? slice[owner_reg] : '0;
                if (!req[owner_reg] || (fifo_w_en && burst_cnt_reg == LAST_BEAT)) begin
                    state_next      = IDLE;
                    grant_next      = '0;
                    last_grant_next = owner_reg;
                    burst_cnt_next  = '0;
                end else if (fifo_w_en) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            grant_reg      <= '0;
            owner_reg      <= '0;
            last_grant_reg <= LAST_IDX;
            burst_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            burst_cnt_reg  <= burst_cnt_next;
        end
    end

    assign grant = grant_reg;
    assign busy  = (state_reg == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomised bench for fifo_wr_arbiter against an owner/beat-count model,
// plus a few directed scenarios with hand-computed expectations.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic           fifo_full = 1'b0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           fifo_w_en;
    logic [W-1:0]   fifo_data;
    logic           busy;

    fifo_wr_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
        .fifo_full(fifo_full), .req_ready(req_ready), .grant(grant),
        .fifo_w_en(fifo_w_en), .fifo_data(fifo_data), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    bit check_en = 1'b0;

    // Model: current owner (-1 when idle), beats done in this grant, last owner.
    int m_owner = -1;
    int m_beats = 0;
    int m_last  = N - 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always begin
        logic [N-1:0] e_grant, e_ready;
        logic         e_wen;
        logic [W-1:0] e_data;
        bit           xfer;
        @(negedge clk);
        if (check_en) begin
            e_grant = '0; e_ready = '0; e_wen = 1'b0; e_data = '0;
            if (m_owner >= 0) begin
                e_grant = N'(1 << m_owner);
                if (rst_n) begin
                    e_ready = fifo_full ? '0 : N'(1 << m_owner);
                    e_wen   = req[m_owner] && !fifo_full;
                    e_data  = W'(req_data >> (m_owner * W));
                end
            end
            chk("grant", 64'(grant), 64'(e_grant));
            chk("busy", 64'(busy), 64'(m_owner >= 0));
            chk("req_ready", 64'(req_ready), 64'(e_ready));
            chk("fifo_w_en", 64'(fifo_w_en), 64'(e_wen));
            chk("fifo_data", 64'(fifo_data), 64'(e_data));
        end
        @(posedge clk);
        if (!rst_n) begin
            m_owner = -1; m_beats = 0; m_last = N - 1;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && req[(m_last + k) % N]) m_owner = (m_last + k) % N;
            end
            m_beats = 0;
        end else if (!req[m_owner]) begin
            m_last = m_owner; m_owner = -1;
        end else begin
            xfer = !fifo_full;
            if (xfer) m_beats++;
            if (m_beats == MB) begin
                m_last = m_owner; m_owner = -1; m_beats = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [N-1:0] rr_exp [5];
        logic [N-1:0] prev;
        int seen, gap, run_len;
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

        repeat (3) step();
        check_en = 1'b1;
        chk("reset_grant", 64'(grant), 64'h0);

        // Single requester 0, data A1 held six cycles.
        rst_n = 1'b1; req = 4'b0001; req_data = 32'h0000_00A1;
        @(negedge clk); chk("a_t0_grant", 64'(grant), 64'h0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            chk("a_beat_grant", 64'(grant), 64'h1);
            chk("a_beat_wen", 64'(fifo_w_en), 64'h1);
            chk("a_beat_data", 64'(fifo_data), 64'hA1);
        end
        @(negedge clk); chk("a_idle_grant", 64'(grant), 64'h0);
        step(); req = 4'b0000;
        @(negedge clk);
        chk("a_regrant", 64'(grant), 64'h1);
        chk("a_drop_wen", 64'(fifo_w_en), 64'h0);
        step(); step();

        // All requesting after reset: round-robin starting at requester 0.
        rst_n = 1'b0; step();
        rst_n = 1'b1; req = 4'b1111; req_data = 32'h44332211;
        seen = 0; gap = 0; run_len = 0; prev = '0;
        for (int c = 0; c < 80 && seen < 5; c++) begin
            @(negedge clk);
            if (grant != 0) begin
                if (prev == 0) begin
                    chk("rr_order", 64'(grant), 64'(rr_exp[seen]));
                    if (seen > 0) chk("rr_gap", 64'(gap), 64'h1);
                    seen++;
                    run_len = 0;
                end
                run_len++;
                if (seen < 5 && run_len > 0 && fifo_w_en != 1'b1) chk("rr_wen", 64'(fifo_w_en), 64'h1);
                gap = 0;
            end else begin
                if (prev != 0) chk("rr_burst_len", 64'(run_len), 64'(MB));
                gap++;
            end
            prev = grant;
        end
        chk("rr_count", 64'(seen), 64'h5);

        // Reset during the second beat of requester 3.
        step(); rst_n = 1'b0; step();
        rst_n = 1'b1; req = 4'b1000; req_data = 32'hC300_0000;
        step(); step();
        rst_n = 1'b0;
        @(negedge clk);
        chk("r_busy_before_edge", 64'(grant), 64'h8);
        chk("r_no_write", 64'(fifo_w_en), 64'h0);
        step();
        rst_n = 1'b1; req = 4'b1001;
        @(negedge clk); chk("r_after_grant", 64'(grant), 64'h0);
        step();
        @(negedge clk); chk("r_first_owner", 64'(grant), 64'h1);

        // Randomised traffic with backpressure and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            step();
            rst_n = ($urandom_range(0, 149) != 0);
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 99) < 15) req[b] = ~req[b];
            fifo_full = ($urandom_range(0, 3) == 0);
            req_data  = $urandom;
        end
        step();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
